// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU sequencer: opcode and FSM encodings,
// instruction field positions and opcode legality decode.
package alu_seq_pkg;

  localparam int OP_W  = 4;
  localparam int SEL_W = 3;

  // Field positions inside instr, in units of AW counted from the LSB.
  // instr = {op, rd, rs1, rs2}; the op field is OP_W bits wide.
  localparam int RS2_FIELD = 0;
  localparam int RS1_FIELD = 1;
  localparam int RD_FIELD  = 2;
  localparam int OP_FIELD  = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_OP0 = 4'b0000,
    ALU_OP1 = 4'b0001,
    ALU_OP2 = 4'b0010,
    ALU_OP3 = 4'b0011,
    ALU_OP4 = 4'b0100,
    LOADI   = 4'b1000
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  // ALU opcodes use op[3]=0 and selects 000..100 only.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return !op[3] && (op[SEL_W-1:0] <= 3'd4);
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return is_alu_op(op) || (op == LOADI);
  endfunction

endpackage

// File: rtl/alu_seq_rf.sv
// NREG x DW register file: one synchronous write port, three asynchronous
// read ports (two operands plus a debug peek), asynchronously cleared.
module alu_seq_rf
  import alu_seq_pkg::*;
#(
  parameter int DW   = 4,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] raddr3,
  output logic [DW-1:0] rdata3
);

  logic [DW-1:0] mem_q [NREG];

  // Storage update: clear every entry on reset, otherwise single-port write.
  // NOTE: this array is reset on purpose -- a reset mid-instruction must leave
  // every register at zero, so it cannot map to an un-resettable RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];
  assign rdata3 = mem_q[raddr3];

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: accepts one instruction at a time, reads operands from the
// register file, drives the external combinational ALU, writes the result
// back once and returns it over a valid/ready handshake.
// Optional build macro ALU_SEQ_CTRL_ZFLAG_EN adds the res_zero output.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter  int DW   = 4,
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG),
  localparam int IW   = OP_W + 3 * AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_err,
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
  output logic          res_zero,
`endif
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [DW-1:0] alu_in1_q, alu_in1_d;
  logic [DW-1:0] alu_in2_q, alu_in2_d;
  logic [2:0]    alu_sel_q, alu_sel_d;
  logic [DW-1:0] result_q, result_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
  logic          res_zero_q, res_zero_d;
`endif

  logic [OP_W-1:0] op;
  logic [AW-1:0]   rd, rs1, rs2;
  logic [2*AW-1:0] imm;
  logic [DW-1:0]   rs1_data, rs2_data;
  logic            rf_we;

  // Field decode always works on the latched instruction, never on instr.
  assign op  = ir_q[OP_FIELD*AW +: OP_W];
  assign rd  = ir_q[RD_FIELD*AW +: AW];
  assign rs1 = ir_q[RS1_FIELD*AW +: AW];
  assign rs2 = ir_q[RS2_FIELD*AW +: AW];
  assign imm = {rs1, rs2};

  alu_seq_rf #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (result_q),
    .raddr1 (rs1),
    .rdata1 (rs1_data),
    .raddr2 (rs2),
    .rdata2 (rs2_data),
    .raddr3 (dbg_addr),
    .rdata3 (dbg_data)
  );

  // Next-state and datapath decode for the four-phase instruction sequence.
  // NOTE: every target gets its hold value first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_sel_d   = alu_sel_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    res_zero_d  = res_zero_q;
`endif
    rf_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = READ;
        end
      end
      READ: begin
        // LOADI and illegal codes leave the ALU drive untouched.
        if (is_alu_op(op)) begin
          alu_in1_d = rs1_data;
          alu_in2_d = rs2_data;
          alu_sel_d = op[SEL_W-1:0];
        end
        state_d = EXEC;
      end
      EXEC: begin
        if (is_alu_op(op))   result_d = alu_out;
        else if (op == LOADI) result_d = DW'(imm);
        else                  result_d = '0;
        state_d = WB;
      end
      WB: begin
        // First WB cycle (res_valid still low) performs the single write.
        if (!res_valid_q) begin
          rf_we       = is_legal(op);
          res_valid_d = 1'b1;
          res_data_d  = result_q;
          res_err_d   = !is_legal(op);
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
          res_zero_d  = (result_q == '0) && is_legal(op);
`endif
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and all registered outputs.
  // NOTE: non-blocking assignments here so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_sel_q   <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
      res_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_sel_q   <= alu_sel_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
      res_zero_q  <= res_zero_d;
`endif
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign alu_sel     = alu_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
  assign res_zero    = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: provides a reference 4-bit ALU, drives directed
// instructions, and compares the DUT every cycle against an instruction-level
// model (register array + expected result / latency).
module tb_alu_seq_ctrl;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [3:0] alu_in1, alu_in2, alu_out;
  logic [2:0] alu_sel;
  logic       res_valid, res_ready, res_err;
  logic [3:0] res_data;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
  logic       res_zero;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    .res_zero    (res_zero),
`endif
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Stand-in for the team ALU: add, sub, and, or, xor.
  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_in1, alu_in2, alu_sel);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  logic [3:0] m_rf [4];
  logic [3:0] last_in1, last_in2;
  logic [2:0] last_sel;
  bit         pending;
  int         cyc, acc;
  logic [3:0] e_data, e_in1, e_in2;
  logic [2:0] e_sel;
  logic [1:0] e_rd;
  bit         e_err, e_wr;

  // Edge bookkeeping: accept, writeback commit and result handshake.
  always @(posedge clk) begin
    logic [3:0] op;
    logic [1:0] a, b;
    cyc++;
    if (!rst_n) begin
      pending = 0;
      for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
      last_in1 = 0; last_in2 = 0; last_sel = 0;
    end else begin
      if (pending && res_valid && res_ready) pending = 0;
      if (instr_valid && instr_ready) begin
        op = instr[9:6]; e_rd = instr[5:4]; a = instr[3:2]; b = instr[1:0];
        if (op[3] == 1'b0 && op[2:0] <= 3'd4) begin
          last_in1 = m_rf[a]; last_in2 = m_rf[b]; last_sel = op[2:0];
          e_data = alu_fn(m_rf[a], m_rf[b], op[2:0]); e_err = 0; e_wr = 1;
        end else if (op == 4'b1000) begin
          e_data = {a, b}; e_err = 0; e_wr = 1;
        end else begin
          e_data = 4'd0; e_err = 1; e_wr = 0;
        end
        e_in1 = last_in1; e_in2 = last_in2; e_sel = last_sel;
        pending = 1; acc = cyc;
      end
      if (pending && (cyc - acc == 3) && e_wr) m_rf[e_rd] = e_data;
    end
  end

  // Per-cycle compare, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    int d;
    if (!rst_n) begin
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_err", res_err, 0);
      check("rst_alu_in1", alu_in1, 0);
      check("rst_alu_in2", alu_in2, 0);
      check("rst_alu_sel", alu_sel, 0);
      check("rst_instr_ready", instr_ready, 1);
      check("rst_dbg_data", dbg_data, 0);
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
      check("rst_res_zero", res_zero, 0);
`endif
    end else begin
      check("dbg_data", dbg_data, m_rf[dbg_addr]);
      if (pending) begin
        d = cyc - acc;
        check("instr_ready_busy", instr_ready, 0);
        if (d == 1) begin
          check("exec_alu_in1", alu_in1, e_in1);
          check("exec_alu_in2", alu_in2, e_in2);
          check("exec_alu_sel", alu_sel, e_sel);
        end
        if (d < 3) check("res_valid_early", res_valid, 0);
        else begin
          check("res_valid", res_valid, 1);
          check("res_data", res_data, e_data);
          check("res_err", res_err, e_err);
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
          check("res_zero", res_zero, (e_data == 0) && !e_err);
`endif
        end
      end else begin
        check("idle_instr_ready", instr_ready, 1);
        check("idle_res_valid", res_valid, 0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at ~1 time unit after a rising edge; returns at the same phase.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] a,
                       input logic [1:0] b, input int stall, output logic [3:0] data,
                       output logic err, output logic z);
    bit ok;
    instr = {op, rd, a, b}; instr_valid = 1; res_ready = (stall == 0);
    data = 'x; err = 'x; z = 'x;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) begin ok = 1; break; end
    end
    if (!ok) begin check("accept_timeout", 0, 1); instr_valid = 0; return; end
    @(posedge clk); #1 instr_valid = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; break; end
    end
    if (!ok) begin check("result_timeout", 0, 1); res_ready = 1; return; end
    data = res_data; err = res_err; z = 1'b0;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    z = res_zero;
`endif
    if (stall > 0) begin
      // Stray instruction offered while the result is stalled.
      @(posedge clk); #1 instr = {4'b1000, 2'd0, 2'd3, 2'd3}; instr_valid = 1;
      repeat (stall - 1) @(posedge clk);
      #1 instr_valid = 0; res_ready = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [1:0] a, input logic [3:0] exp);
    dbg_addr = a; #1;
    check($sformatf("peek_r%0d", a), dbg_data, exp);
  endtask

  initial begin : stim
    logic [3:0] d;
    logic       e, z;
    rst_n = 0; instr_valid = 0; instr = '0; res_ready = 1; dbg_addr = 0;
    cyc = 0; acc = 0; pending = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Load and peek
    issue(4'b1000, 2'd1, 2'd1, 2'd0, 0, d, e, z); check("loadi_r1", d, 4); check("loadi_r1_err", e, 0);
    issue(4'b1000, 2'd2, 2'd2, 2'd1, 0, d, e, z); check("loadi_r2", d, 9); check("loadi_r2_err", e, 0);
    peek(2'd1, 4'd4);
    peek(2'd2, 4'd9);

    // ALU sequencing r3 = r1 op r2 (4 op 9)
    issue(4'b0010, 2'd3, 2'd1, 2'd2, 0, d, e, z); check("and_4_9", d, 4'd0);
    peek(2'd3, 4'd0);
    issue(4'b0000, 2'd3, 2'd1, 2'd2, 0, d, e, z); check("add_4_9", d, 4'd13);
    issue(4'b0001, 2'd3, 2'd1, 2'd2, 0, d, e, z); check("sub_4_9", d, 4'd11);
    issue(4'b0100, 2'd3, 2'd1, 2'd2, 0, d, e, z); check("xor_4_9", d, 4'd13);
    issue(4'b0011, 2'd3, 2'd1, 2'd2, 0, d, e, z); check("or_4_9", d, 4'd13);
    peek(2'd3, 4'd13);

    // Illegal opcodes
    issue(4'b0110, 2'd1, 2'd0, 2'd0, 0, d, e, z); check("ill_0110_data", d, 0); check("ill_0110_err", e, 1);
    peek(2'd1, 4'd4);
    issue(4'b1111, 2'd2, 2'd1, 2'd1, 0, d, e, z); check("ill_1111_data", d, 0); check("ill_1111_err", e, 1);
    peek(2'd2, 4'd9);

    // Backpressure: result held for several cycles, stray instr ignored
    issue(4'b1000, 2'd3, 2'd1, 2'd2, 5, d, e, z); check("stall_loadi", d, 6);
    peek(2'd3, 4'd6);
    peek(2'd0, 4'd0);

    // rd == rs reads the old value
    issue(4'b0000, 2'd1, 2'd1, 2'd1, 0, d, e, z); check("add_r1_r1", d, 8);
    peek(2'd1, 4'd8);

    // Reset in the middle of EXEC
    instr = {4'b1000, 2'd3, 2'd3, 2'd3}; instr_valid = 1;
    @(negedge clk); check("pre_rst_ready", instr_ready, 1);
    @(posedge clk); #1 instr_valid = 0;
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 4; i++) peek(2'(i), 4'd0);
    check("post_rst_ready", instr_ready, 1);
    issue(4'b1000, 2'd2, 2'd0, 2'd3, 0, d, e, z); check("post_rst_loadi", d, 3);
    issue(4'b0000, 2'd0, 2'd2, 2'd2, 0, d, e, z); check("post_rst_add", d, 6);
    peek(2'd0, 4'd6);

`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    issue(4'b1000, 2'd0, 2'd0, 2'd0, 0, d, e, z); check("zflag_zero", z, 1);
    issue(4'b1000, 2'd0, 2'd1, 2'd1, 0, d, e, z); check("zflag_five", z, 0);
    issue(4'b0111, 2'd0, 2'd0, 2'd0, 0, d, e, z); check("zflag_illegal", z, 0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
